// File: rtl/data_mem_pkg.sv
// Shared types and default widths for the data-memory arbiter slice.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    DONE
  } state_t;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 16;

endpackage

// File: rtl/data_mem_arbiter_rr.sv
// Round-robin winner select: first requester at/after the pointer, wrapping.
// The pointer advances past the last served requester when upd is high.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd,
  input  logic [ID_W-1:0]    upd_id,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (upd) begin
      ptr <= (upd_id == ID_W'(NUM_REQ - 1)) ? '0 : upd_id + 1'b1;
    end
  end

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data memory between NUM_REQ requesters; sequences setup,
// single-cycle read/write strobe and ack through a four-state FSM.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_read,
  output logic                      mem_write,
  input  logic [DATA_W-1:0]         mem_rdata
);

  state_t              state_q, state_d;
  logic                op_we_q, op_we_d;
  logic [NUM_REQ-1:0]  ack_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                busy_d;
  logic [ID_W-1:0]     grant_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                mem_read_d, mem_write_d;
  logic [ID_W-1:0]     winner;
  logic                any_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .upd    (state_q == DONE),
    .upd_id (grant_id),
    .winner (winner),
    .any    (any_req)
  );

  // Every output is computed one state ahead so it is registered when seen.
  always_comb begin
    state_d     = state_q;
    op_we_d     = op_we_q;
    ack_d       = '0;
    rdata_d     = rdata;
    grant_d     = grant_id;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = SETUP;
          grant_d     = winner;
          op_we_d     = req_we[winner];
          mem_addr_d  = req_addr[winner*ADDR_W +: ADDR_W];
          mem_wdata_d = req_wdata[winner*DATA_W +: DATA_W];
        end
      end
      SETUP: begin
        state_d     = STROBE;
        mem_write_d = op_we_q;
        mem_read_d  = !op_we_q;
      end
      STROBE: begin
        state_d         = DONE;
        ack_d[grant_id] = 1'b1;
        if (!op_we_q) rdata_d = mem_rdata;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_we_q   <= 1'b0;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_we_q   <= op_we_d;
      ack       <= ack_d;
      rdata     <= rdata_d;
      busy      <= busy_d;
      grant_id  <= grant_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with an edge-triggered 256x16 memory model.
module tb_data_mem_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 16;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic                      grant_id;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_read;
  logic                      mem_write;
  logic [DATA_W-1:0]         mem_rdata;

  data_mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .grant_id  (grant_id),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge mem_write) mem[mem_addr] <= mem_wdata;
  always @(posedge mem_read)  mem_rdata <= mem[mem_addr];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol monitor, sampled on the falling edge.
  logic       prev_rd, prev_wr, prev_busy;
  logic [7:0] prev_addr;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("strobe_excl", 64'(mem_read & mem_write), 64'd0);
      if (prev_rd) chk("rd_width", 64'(mem_read), 64'd0);
      if (prev_wr) chk("wr_width", 64'(mem_write), 64'd0);
      chk("ack_onehot0", 64'($onehot0(ack)), 64'd1);
      if (ack != 0) chk("ack_to_grant", 64'(ack), 64'(1 << grant_id));
      if (prev_busy && busy) chk("addr_stable", 64'(mem_addr), 64'(prev_addr));
      prev_rd   = mem_read;
      prev_wr   = mem_write;
      prev_busy = busy;
      prev_addr = mem_addr;
    end else begin
      prev_rd   = 1'b0;
      prev_wr   = 1'b0;
      prev_busy = 1'b0;
      prev_addr = '0;
    end
  end

  task automatic drive(input int who, input logic r, input logic we,
                       input logic [7:0] a, input logic [15:0] d);
    req[who]                = r;
    req_we[who]             = we;
    req_addr[who*8 +: 8]    = a;
    req_wdata[who*16 +: 16] = d;
  endtask

  typedef struct {
    int          who;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  task automatic do_txn(input vec_t v);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    drive(v.who, 1'b1, v.we, v.addr, v.wdata);
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (ack != 0) got = 1'b1;
    end
    chk("txn_ack_seen", 64'(got), 64'd1);
    chk("txn_latency", 64'(n), 64'd3);
    chk("txn_ack", 64'(ack), 64'(1 << v.who));
    chk("txn_grant", 64'(grant_id), 64'(v.who));
    chk("txn_rdata", 64'(rdata), 64'(v.exp_rdata));
    req[v.who] = 1'b0;
    @(negedge clk);
    chk("txn_idle", 64'(busy), 64'd0);
  endtask

  vec_t vecs[10];
  vec_t extra;
  int   ids[4], cyc_at[4], na;
  int   exp_ids[4] = '{0, 1, 0, 1};
  int   acks, bad_consec, pulses, ack_at;
  logic got1, last0;

  initial begin
    vecs[0] = '{0, 1'b1, 8'h10, 16'hBEEF, 16'h0000};
    vecs[1] = '{0, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
    vecs[2] = '{1, 1'b1, 8'hFF, 16'h1234, 16'hBEEF};
    vecs[3] = '{1, 1'b1, 8'h00, 16'h5678, 16'hBEEF};
    vecs[4] = '{0, 1'b0, 8'hFF, 16'h0000, 16'h1234};
    vecs[5] = '{1, 1'b0, 8'h00, 16'h0000, 16'h5678};
    vecs[6] = '{1, 1'b1, 8'h01, 16'h0A0A, 16'h5678};
    vecs[7] = '{0, 1'b0, 8'h01, 16'h0000, 16'h0A0A};
    vecs[8] = '{1, 1'b0, 8'h20, 16'h0000, 16'h7777};
    vecs[9] = '{0, 1'b0, 8'h11, 16'h0000, 16'h0000};

    rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {ack, rdata, busy, grant_id, mem_addr, mem_wdata, mem_read, mem_write}, 64'd0);

    // Reset while the write strobe is high: strobe drops at once, write already committed.
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b1, 8'h20, 16'h7777);
    @(negedge clk);
    chk("setup_no_strobe", 64'({mem_read, mem_write}), 64'd0);
    chk("setup_addr", 64'(mem_addr), 64'h20);
    @(negedge clk);
    chk("strobe_write_high", 64'({mem_read, mem_write}), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {ack, rdata, busy, grant_id, mem_addr, mem_wdata, mem_read, mem_write}, 64'd0);
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Contention: both requesters held from reset release.
    drive(0, 1'b1, 1'b0, 8'h20, 16'h0000);
    drive(1, 1'b1, 1'b0, 8'h21, 16'h0000);
    @(negedge clk);
    chk("idle_in_reset", 64'(busy), 64'd0);
    rst_n = 1'b1;
    na = 0;
    for (int c = 1; c <= 40 && na < 4; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        ids[na]    = ack[1] ? 1 : 0;
        cyc_at[na] = c;
        chk("cont_grant_id", 64'(grant_id), 64'(exp_ids[na]));
        na++;
      end
    end
    req = '0;
    chk("cont_ack_count", 64'(na), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_order", 64'(ids[i]), 64'(exp_ids[i]));
      chk("cont_spacing", 64'(cyc_at[i]), 64'(3 + 4 * i));
    end
    @(negedge clk);
    chk("cont_last_rdata", 64'(rdata), 64'h0000);

    foreach (vecs[i]) do_txn(vecs[i]);

    // Fairness: requester 0 held, requester 1 raised mid-transaction.
    drive(0, 1'b1, 1'b0, 8'h10, 16'h0000);
    repeat (2) @(negedge clk);
    drive(1, 1'b1, 1'b1, 8'h40, 16'h4444);
    acks = 0; bad_consec = 0; got1 = 1'b0; last0 = 1'b0;
    for (int c = 0; c < 40 && !got1; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        acks++;
        if (ack[1]) begin
          got1   = 1'b1;
          req[1] = 1'b0;
        end else begin
          if (last0) bad_consec++;
          last0 = 1'b1;
        end
      end
    end
    req[0] = 1'b0;
    chk("fair_req1_served", 64'(got1), 64'd1);
    chk("fair_acks_until_req1", 64'(acks), 64'd2);
    chk("fair_no_double0", 64'(bad_consec), 64'd0);
    @(negedge clk);
    extra = '{0, 1'b0, 8'h40, 16'h0000, 16'h4444};
    do_txn(extra);

    // Abandon: requester 1 drops its write request once in SETUP.
    drive(1, 1'b1, 1'b1, 8'h50, 16'h5555);
    @(negedge clk);
    chk("abandon_in_setup", 64'(busy), 64'd1);
    req[1] = 1'b0;
    pulses = 0; ack_at = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ack[1]) begin
        pulses++;
        ack_at = c;
        chk("abandon_rdata_held", 64'(rdata), 64'h4444);
      end
      chk("abandon_no_ack0", 64'(ack[0]), 64'd0);
    end
    chk("abandon_ack_pulses", 64'(pulses), 64'd1);
    chk("abandon_ack_cycle", 64'(ack_at), 64'd2);
    extra = '{0, 1'b0, 8'h50, 16'h0000, 16'h5555};
    do_txn(extra);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
